// File: rtl/quadra_arbiter.sv
// Round-robin front end for a shared, non-stalling quadratic evaluator core.
// Issues at most one argument per cycle, tracks the owner of every in-flight
// operation in a tag pipeline matched to the core latency, and returns each
// result tagged with its requester ID.
module quadra_arbiter #(
   parameter int N_REQ    = 4,
   parameter int X_W      = 24,
   parameter int Y_W      = 30,
   parameter int CORE_LAT = 3,
   parameter int ID_W     = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [N_REQ-1:0]       req_vld,
   input  logic [N_REQ*X_W-1:0]   req_x,
   output logic [N_REQ-1:0]       req_rdy,
   output logic                   core_x_vld,
   output logic [X_W-1:0]         core_x,
   input  logic                   core_y_vld,
   input  logic [Y_W-1:0]         core_y,
   output logic                   rsp_vld,
   output logic [ID_W-1:0]        rsp_id,
   output logic [Y_W-1:0]         rsp_y,
   output logic                   busy,
   output logic                   err
);

   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic                gnt_found;
   logic [ID_W-1:0]     gnt_id;
   logic                grant;

   logic                core_x_vld_q, core_x_vld_d;
   logic [X_W-1:0]      core_x_q, core_x_d;
   logic [ID_W-1:0]     issue_id_q, issue_id_d;

   logic [CORE_LAT-1:0] tag_vld_q, tag_vld_d;
   logic [ID_W-1:0]     tag_id_q [CORE_LAT];
   logic [ID_W-1:0]     tag_id_d [CORE_LAT];
   logic                tail_vld;
   logic [ID_W-1:0]     tail_id;

   logic                rsp_vld_q, rsp_vld_d;
   logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
   logic [Y_W-1:0]      rsp_y_q, rsp_y_d;
   logic                err_q, err_d;

   // Find the first valid requester at or after the round-robin pointer.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_id    = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = (32'(ptr_q) + k) % N_REQ;
         if (!gnt_found && req_vld[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = ID_W'(idx);
         end
      end
   end

   assign grant = en & ~rst & gnt_found;

   // One-hot grant, and next pointer / issue-stage values.
   always_comb begin
      req_rdy      = '0;
      ptr_d        = ptr_q;
      core_x_vld_d = grant;
      core_x_d     = core_x_q;
      issue_id_d   = issue_id_q;
      if (grant) begin
         req_rdy[gnt_id] = 1'b1;
         ptr_d           = ID_W'((32'(gnt_id) + 1) % N_REQ);
         core_x_d        = req_x[32'(gnt_id)*X_W +: X_W];
         issue_id_d      = gnt_id;
      end
   end

   // Tag pipeline advances every cycle so its tail lines up with core_y_vld.
   always_comb begin
      tag_vld_d    = '0;
      tag_vld_d[0] = core_x_vld_q;
      tag_id_d[0]  = issue_id_q;
      for (int unsigned i = 1; i < CORE_LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end
   end

   assign tail_vld = tag_vld_q[CORE_LAT-1];
   assign tail_id  = tag_id_q[CORE_LAT-1];

   // Response capture; any disagreement between core strobe and tail valid is sticky.
   always_comb begin
      rsp_vld_d = core_y_vld & tail_vld;
      rsp_id_d  = rsp_id_q;
      rsp_y_d   = rsp_y_q;
      if (core_y_vld && tail_vld) begin
         rsp_id_d = tail_id;
         rsp_y_d  = core_y;
      end
      err_d = err_q | (core_y_vld ^ tail_vld);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q        <= '0;
         core_x_vld_q <= 1'b0;
         core_x_q     <= '0;
         issue_id_q   <= '0;
         tag_vld_q    <= '0;
         for (int unsigned i = 0; i < CORE_LAT; i++) begin
            tag_id_q[i] <= '0;
         end
         rsp_vld_q    <= 1'b0;
         rsp_id_q     <= '0;
         rsp_y_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         ptr_q        <= ptr_d;
         core_x_vld_q <= core_x_vld_d;
         core_x_q     <= core_x_d;
         issue_id_q   <= issue_id_d;
         tag_vld_q    <= tag_vld_d;
         for (int unsigned i = 0; i < CORE_LAT; i++) begin
            tag_id_q[i] <= tag_id_d[i];
         end
         rsp_vld_q    <= rsp_vld_d;
         rsp_id_q     <= rsp_id_d;
         rsp_y_q      <= rsp_y_d;
         err_q        <= err_d;
      end
   end

   assign core_x_vld = core_x_vld_q;
   assign core_x     = core_x_q;
   assign rsp_vld    = rsp_vld_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_y      = rsp_y_q;
   assign err        = err_q;
   assign busy       = core_x_vld_q | (|tag_vld_q) | rsp_vld_q;

endmodule
